mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single Avalon-style memory port between the CPU's instruction-fetch requester and its load/store requester. Each requester gets a simple req/ready interface. The arbiter serialises their transactions onto the memory bus, honours `mem_waitrequest`, captures read data, and rejects misaligned word addresses without touching the bus. It sits between the CPU core and the memory (instruction/data RAM) in the top level.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width on both sides.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_req`  in  1  fetch request; held high until `instr_ready`.
- `instr_addr`  in  ADDR_W  fetch byte address; stable while `instr_req` is high.
- `instr_ready`  out  1  one-cycle completion pulse.
- `instr_rdata`  out  32  fetched word; valid when `instr_ready` is high.
- `instr_err`  out  1  misaligned fetch; qualified by `instr_ready`.
- `data_req`  in  1  load/store request; held until `data_ready`.
- `data_we`  in  1  1 = write, 0 = read.
- `data_addr`  in  ADDR_W  byte address.
- `data_wdata`  in  32  write data.
- `data_be`  in  4  byte enables.
- `data_ready`  out  1  one-cycle completion pulse.
- `data_rdata`  out  32  read word; valid when `data_ready` is high (reads only).
- `data_err`  out  1  misaligned access; qualified by `data_ready`.
- `mem_address`  out  ADDR_W  bus address.
- `mem_read`  out  1  bus read strobe.
- `mem_write`  out  1  bus write strobe.
- `mem_writedata`  out  32  bus write data.
- `mem_byteenable`  out  4  bus byte enables.
- `mem_waitrequest`  in  1  stall: the transfer is not accepted while this is high.
- `mem_readdata`  in  32  valid exactly one cycle after read acceptance.

## Operation
- FSM states:
  - IDLE: no bus activity.
  - ISSUE: `mem_read` or `mem_write` asserted.
  - RDWAIT: waiting for read data.
- Grant flag `owner` selects INSTR or DATA. `last_grant` resets to INSTR.
- IDLE arbitration:
  - A request counts as pending only if its req is high and its own ready is not high this cycle (a stale req during ready is ignored).
  - One pending request: grant it.
  - Both pending: grant the one not equal to `last_grant`, i.e. round-robin. After reset, DATA wins.
- Alignment check in IDLE, applied to the granted request:
  - A request is misaligned if `addr[1:0]` != 0.
  - On a misaligned request, the FSM stays in IDLE. Next cycle: ready=1, err=1, rdata=0.
  - No bus strobe is asserted. `last_grant` is still updated.
- Aligned grant → ISSUE, with registered outputs:
  - `mem_address` = requester addr.
  - INSTR: `mem_read`=1, `mem_byteenable`=4'b1111, `mem_writedata`=0.
  - DATA: `mem_read`=!we, `mem_write`=we, `mem_byteenable`=`data_be`, `mem_writedata`=`data_wdata`.
- ISSUE:
  - All `mem_*` outputs are held constant while `mem_waitrequest`=1.
  - When `mem_waitrequest`=0 (acceptance), strobes drop on the next edge.
  - Write: → IDLE, and `data_ready` pulses next cycle.
  - Read: → RDWAIT.
- RDWAIT:
  - Capture `mem_readdata` into the owner's rdata register.
  - The owner's ready pulses next cycle; → IDLE.
- `instr_rdata`/`data_rdata` hold their last captured value until overwritten.
- err is 0 on every normal completion.
- `data_be`=4'b0000 is passed through unchanged; it is not an error.
- Requests arriving while not in IDLE wait. Neither requester's fields are sampled until it is granted.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, `last_grant`=INSTR.
  - All outputs 0, including rdata registers.
- Reset mid-transaction: any strobe drops immediately and the transaction is abandoned. No ready pulse is produced. Requesters must re-issue.
- Let N be the IDLE cycle in which a request is granted, and A the first ISSUE cycle with `mem_waitrequest`=0.
- ISSUE begins at N+1.
- Read: RDWAIT at A+1, ready at A+2. Minimum is N+3.
- Write: ready at A+1. Minimum is N+2.
- Misaligned: ready/err at N+1.
- The next arbitration can occur in the cycle a ready is high. Back-to-back minimum spacing:
  - 3 cycles between read grants.
  - 2 cycles between write grants.
- Only one of `instr_ready`/`data_ready` is high in any cycle.
- `mem_read` and `mem_write` are never high together.

## Test plan
- Reset, then `instr_req`=1, `instr_addr`=0xBFC00000, `mem_waitrequest`=0, `mem_readdata`=0x24020005:
  - `mem_read`=1 only in cycle N+1, with `mem_address`=0xBFC00000 and byteenable 4'b1111.
  - `instr_ready`=1 with `instr_rdata`=0x24020005 at N+3.
- Store: `data_we`=1, addr 0x1000, wdata 0xDEADBEEF, be 4'b0011, `mem_waitrequest` high for 3 cycles:
  - `mem_write` stays high 4 cycles with all fields stable.
  - `data_ready` one cycle after acceptance.
  - `data_err`=0.
- Both requests raised in the same cycle after reset, then held (re-raised) continuously:
  - Order of grants is DATA, INSTR, DATA, INSTR.
  - No overlapping strobes; each ready pulses exactly once per transaction.
- Misaligned requests, `instr_addr`=0xBFC00002 and `data_addr`=0x1001:
  - Each gets ready=1 with err=1 one cycle after its grant.
  - `mem_read`/`mem_write` are never asserted.
- `reset` asserted while in ISSUE with `mem_waitrequest`=1:
  - `mem_read` drops asynchronously and no ready appears.
  - After release, the re-issued request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory port between instruction
// fetch and load/store requesters; misaligned word accesses complete with err.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_ready,
    output logic [31:0]       instr_rdata,
    output logic              instr_err,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_be,
    output logic              data_ready,
    output logic [31:0]       data_rdata,
    output logic              data_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RDWAIT
    } state_e;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_writedata_q, mem_writedata_d;
    logic [3:0]        mem_byteenable_q, mem_byteenable_d;
    logic              instr_ready_q, instr_ready_d;
    logic              instr_err_q, instr_err_d;
    logic [31:0]       instr_rdata_q, instr_rdata_d;
    logic              data_ready_q, data_ready_d;
    logic              data_err_q, data_err_d;
    logic [31:0]       data_rdata_q, data_rdata_d;

    logic              instr_pend;
    logic              data_pend;
    logic              grant_data;
    logic [ADDR_W-1:0] grant_addr;

    // A req still high during its own ready pulse is the old transaction, not a new one.
    assign instr_pend = instr_req && !instr_ready_q;
    assign data_pend  = data_req && !data_ready_q;
    assign grant_data = data_pend && (!instr_pend || (last_grant_q == OWN_INSTR));
    assign grant_addr = grant_data ? data_addr : instr_addr;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path infers a latch.
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        instr_ready_d    = 1'b0;
        instr_err_d      = 1'b0;
        instr_rdata_d    = instr_rdata_q;
        data_ready_d     = 1'b0;
        data_err_d       = 1'b0;
        data_rdata_d     = data_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (instr_pend || data_pend) begin
                    last_grant_d = grant_data ? OWN_DATA : OWN_INSTR;
                    if (grant_addr[1:0] != 2'b00) begin
                        if (grant_data) begin
                            data_ready_d = 1'b1;
                            data_err_d   = 1'b1;
                            data_rdata_d = '0;
                        end else begin
                            instr_ready_d = 1'b1;
                            instr_err_d   = 1'b1;
                            instr_rdata_d = '0;
                        end
                    end else begin
                        state_d       = S_ISSUE;
                        owner_d       = grant_data ? OWN_DATA : OWN_INSTR;
                        mem_address_d = grant_addr;
                        if (grant_data) begin
                            mem_read_d       = !data_we;
                            mem_write_d      = data_we;
                            mem_byteenable_d = data_be;
                            mem_writedata_d  = data_wdata;
                        end else begin
                            mem_read_d       = 1'b1;
                            mem_write_d      = 1'b0;
                            mem_byteenable_d = 4'b1111;
                            mem_writedata_d  = '0;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (!mem_waitrequest) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_write_q) begin
                        state_d      = S_IDLE;
                        data_ready_d = 1'b1;
                    end else begin
                        state_d = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                state_d = S_IDLE;
                if (owner_q == OWN_DATA) begin
                    data_rdata_d = mem_readdata;
                    data_ready_d = 1'b1;
                end else begin
                    instr_rdata_d = mem_readdata;
                    instr_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            owner_q          <= OWN_INSTR;
            last_grant_q     <= OWN_INSTR;
            mem_address_q    <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            instr_ready_q    <= 1'b0;
            instr_err_q      <= 1'b0;
            instr_rdata_q    <= '0;
            data_ready_q     <= 1'b0;
            data_err_q       <= 1'b0;
            data_rdata_q     <= '0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_grant_q     <= last_grant_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            instr_ready_q    <= instr_ready_d;
            instr_err_q      <= instr_err_d;
            instr_rdata_q    <= instr_rdata_d;
            data_ready_q     <= data_ready_d;
            data_err_q       <= data_err_d;
            data_rdata_q     <= data_rdata_d;
        end
    end

    assign instr_ready    = instr_ready_q;
    assign instr_err      = instr_err_q;
    assign instr_rdata    = instr_rdata_q;
    assign data_ready     = data_ready_q;
    assign data_err       = data_err_q;
    assign data_rdata     = data_rdata_q;
    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps with scoreboard queues for bus
// transfers and requester completions.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ready;
    logic [31:0]       instr_rdata;
    logic              instr_err;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_be;
    logic              data_ready;
    logic [31:0]       data_rdata;
    logic              data_err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;
    logic              mem_waitrequest;
    logic [31:0]       mem_readdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req       (instr_req),
        .instr_addr      (instr_addr),
        .instr_ready     (instr_ready),
        .instr_rdata     (instr_rdata),
        .instr_err       (instr_err),
        .data_req        (data_req),
        .data_we         (data_we),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_be         (data_be),
        .data_ready      (data_ready),
        .data_rdata      (data_rdata),
        .data_err        (data_err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    typedef struct {
        bit          is_data;
        bit          err;
        bit          chk_rdata;
        logic [31:0] rdata;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    bus_t mon_b;
    rsp_t mon_r;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; the monitor looks 1 ns later so it sees them settled.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (mem_read || mem_write)
                check("strobe_excl", 32'(mem_read && mem_write), 32'd0);
            if (instr_ready || data_ready)
                check("ready_excl", 32'(instr_ready && data_ready), 32'd0);
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'(mem_address), 32'hFFFF_FFFF);
                end else begin
                    mon_b = bus_q.pop_front();
                    check("bus_we", 32'(mem_write), 32'(mon_b.we));
                    check("bus_addr", mem_address, mon_b.addr);
                    check("bus_wdata", mem_writedata, mon_b.wdata);
                    check("bus_be", 32'(mem_byteenable), 32'(mon_b.be));
                end
            end
            if (instr_ready || data_ready) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'({instr_ready, data_ready}), 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_owner", 32'(data_ready), 32'(mon_r.is_data));
                    check("rsp_err", 32'(mon_r.is_data ? data_err : instr_err), 32'(mon_r.err));
                    if (mon_r.chk_rdata)
                        check("rsp_rdata", mon_r.is_data ? data_rdata : instr_rdata, mon_r.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nready;
        int got;

        reset           = 1'b1;
        instr_req       = 1'b0;
        instr_addr      = '0;
        data_req        = 1'b0;
        data_we         = 1'b0;
        data_addr       = '0;
        data_wdata      = '0;
        data_be         = '0;
        mem_waitrequest = 1'b0;
        mem_readdata    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_instr_ready", 32'(instr_ready), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_instr_rdata", instr_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        reset = 1'b0;

        // Single aligned fetch, no wait states: strobe at N+1, ready at N+3
        @(negedge clk);
        bus_q.push_back('{we: 1'b0, addr: 32'hBFC0_0000, wdata: 32'h0, be: 4'hF});
        rsp_q.push_back('{is_data: 1'b0, err: 1'b0, chk_rdata: 1'b1, rdata: 32'h2402_0005});
        mem_readdata = 32'h2402_0005;
        instr_addr   = 32'hBFC0_0000;
        instr_req    = 1'b1;
        @(negedge clk);
        check("t1_read_n1", 32'(mem_read), 32'd1);
        check("t1_addr_n1", mem_address, 32'hBFC0_0000);
        check("t1_be_n1", 32'(mem_byteenable), 32'hF);
        @(negedge clk);
        check("t1_read_n2", 32'(mem_read), 32'd0);
        check("t1_ready_n2", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("t1_ready_n3", 32'(instr_ready), 32'd1);
        check("t1_rdata_n3", instr_rdata, 32'h2402_0005);
        check("t1_err_n3", 32'(instr_err), 32'd0);
        instr_req = 1'b0;

        // Store stalled by waitrequest for 3 cycles
        @(negedge clk);
        check("t1_no_repeat", 32'(instr_ready), 32'd0);
        bus_q.push_back('{we: 1'b1, addr: 32'h1000, wdata: 32'hDEAD_BEEF, be: 4'b0011});
        rsp_q.push_back('{is_data: 1'b1, err: 1'b0, chk_rdata: 1'b0, rdata: 32'h0});
        data_we         = 1'b1;
        data_addr       = 32'h1000;
        data_wdata      = 32'hDEAD_BEEF;
        data_be         = 4'b0011;
        mem_waitrequest = 1'b1;
        data_req        = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t2_write_hi", 32'(mem_write), 32'd1);
            check("t2_addr", mem_address, 32'h1000);
            check("t2_wdata", mem_writedata, 32'hDEAD_BEEF);
            check("t2_be", 32'(mem_byteenable), 32'b0011);
            check("t2_no_ready", 32'(data_ready), 32'd0);
            if (c == 4) mem_waitrequest = 1'b0;
        end
        @(negedge clk);
        check("t2_write_lo", 32'(mem_write), 32'd0);
        check("t2_ready", 32'(data_ready), 32'd1);
        check("t2_err", 32'(data_err), 32'd0);
        data_req = 1'b0;

        // Zero byte enables pass through as a normal write
        @(negedge clk);
        bus_q.push_back('{we: 1'b1, addr: 32'h2004, wdata: 32'h0BAD_F00D, be: 4'b0000});
        rsp_q.push_back('{is_data: 1'b1, err: 1'b0, chk_rdata: 1'b0, rdata: 32'h0});
        data_addr  = 32'h2004;
        data_wdata = 32'h0BAD_F00D;
        data_be    = 4'b0000;
        data_req   = 1'b1;
        @(negedge clk);
        check("t2b_write", 32'(mem_write), 32'd1);
        check("t2b_be", 32'(mem_byteenable), 32'd0);
        @(negedge clk);
        check("t2b_ready", 32'(data_ready), 32'd1);
        check("t2b_err", 32'(data_err), 32'd0);
        data_req = 1'b0;
        data_we  = 1'b0;

        // Round robin after reset: DATA, INSTR, DATA, INSTR, reads every 3 cycles
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        mem_readdata = 32'h1357_9BDF;
        instr_addr   = 32'h100;
        data_addr    = 32'h2000;
        data_wdata   = 32'h1111_2222;
        data_be      = 4'hF;
        for (int k = 0; k < 2; k++) begin
            bus_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h1111_2222, be: 4'hF});
            rsp_q.push_back('{is_data: 1'b1, err: 1'b0, chk_rdata: 1'b1, rdata: 32'h1357_9BDF});
            bus_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
            rsp_q.push_back('{is_data: 1'b0, err: 1'b0, chk_rdata: 1'b1, rdata: 32'h1357_9BDF});
        end
        instr_req = 1'b1;
        data_req  = 1'b1;
        nready    = 0;
        got       = 0;
        for (int c = 1; c <= 30 && nready < 4; c++) begin
            @(negedge clk);
            if (instr_ready || data_ready) nready++;
            if (nready == 3) data_req = 1'b0;
            if (nready == 4) got = c;
        end
        instr_req = 1'b0;
        check("t3_ready_count", 32'(nready), 32'd4);
        check("t3_last_ready_cycle", 32'(got), 32'd12);
        repeat (4) @(negedge clk);
        check("t3_bus_drained", 32'(bus_q.size()), 32'd0);
        check("t3_rsp_drained", 32'(rsp_q.size()), 32'd0);

        // Misaligned fetch then misaligned store: err at N+1, no strobes
        rsp_q.push_back('{is_data: 1'b0, err: 1'b1, chk_rdata: 1'b1, rdata: 32'h0});
        instr_addr = 32'hBFC0_0002;
        instr_req  = 1'b1;
        @(negedge clk);
        check("t4i_ready", 32'(instr_ready), 32'd1);
        check("t4i_err", 32'(instr_err), 32'd1);
        check("t4i_rdata", instr_rdata, 32'd0);
        check("t4i_no_read", 32'(mem_read), 32'd0);
        instr_req = 1'b0;
        @(negedge clk);
        check("t4i_ready_once", 32'(instr_ready), 32'd0);
        check("t4i_no_read2", 32'(mem_read), 32'd0);
        rsp_q.push_back('{is_data: 1'b1, err: 1'b1, chk_rdata: 1'b1, rdata: 32'h0});
        data_addr = 32'h1001;
        data_we   = 1'b1;
        data_req  = 1'b1;
        @(negedge clk);
        check("t4d_ready", 32'(data_ready), 32'd1);
        check("t4d_err", 32'(data_err), 32'd1);
        check("t4d_rdata", data_rdata, 32'd0);
        check("t4d_no_write", 32'(mem_write), 32'd0);
        data_req = 1'b0;
        data_we  = 1'b0;
        @(negedge clk);
        check("t4d_no_write2", 32'(mem_write), 32'd0);

        // Reset during a stalled fetch abandons it; the re-issued fetch completes
        instr_addr      = 32'h40;
        mem_waitrequest = 1'b1;
        instr_req       = 1'b1;
        @(negedge clk);
        check("t5_read_before", 32'(mem_read), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_read_async_drop", 32'(mem_read), 32'd0);
        check("t5_addr_cleared", mem_address, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("t5_no_ready", 32'(instr_ready), 32'd0);
        end
        bus_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, be: 4'hF});
        rsp_q.push_back('{is_data: 1'b0, err: 1'b0, chk_rdata: 1'b1, rdata: 32'hCAFE_F00D});
        mem_readdata    = 32'hCAFE_F00D;
        mem_waitrequest = 1'b0;
        reset           = 1'b0;
        got             = 0;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            @(negedge clk);
            if (instr_ready) got = c;
        end
        check("t5_ready_cycle", 32'(got), 32'd3);
        check("t5_rdata", instr_rdata, 32'hCAFE_F00D);
        instr_req = 1'b0;

        repeat (3) @(negedge clk);
        check("end_bus_drained", 32'(bus_q.size()), 32'd0);
        check("end_rsp_drained", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
